// File: rtl/axi_stream_pkt_checker.sv
// AXI-Stream sink that applies a programmable tready pattern and checks
// packet framing (beat index, pid, tkeep, length) and pid ordering.
// Ports: clk/rst_n; s_t* stream sink; cfg_* enable, ready pattern, clear;
//        pkt/beat/err counters, sticky err_flags, err_pulse, last_pid.
module axi_stream_pkt_checker #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int PID_WIDTH  = 48,
    parameter int BEAT_WIDTH = 16,
    parameter int MAX_PLEN   = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tkeep,
    input  logic                  s_tlast,
    input  logic                  cfg_enable,
    input  logic [7:0]            cfg_ready_pat,
    input  logic                  cfg_clear,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [4:0]            err_flags,
    output logic                  err_pulse,
    output logic [PID_WIDTH-1:0]  last_pid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BODY    = 2'd1,
        DISCARD = 2'd2
    } state_e;

    // Index of the last beat allowed in a packet.
    localparam logic [BEAT_WIDTH-1:0] LAST_IDX = BEAT_WIDTH'(MAX_PLEN - 1);

    state_e                state_q, state_d;
    logic [2:0]            phase_q, phase_d;
    logic                  s_tready_q, s_tready_d;
    logic [PID_WIDTH-1:0]  cur_pid_q, cur_pid_d;
    logic [PID_WIDTH-1:0]  last_pid_q, last_pid_d;
    logic [BEAT_WIDTH-1:0] exp_beat_q, exp_beat_d;
    logic                  first_q, first_d;
    logic                  pkt_bad_q, pkt_bad_d;
    logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;
    logic [CNT_WIDTH-1:0]  beat_count_q, beat_count_d;
    logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;
    logic [4:0]            err_flags_q, err_flags_d;
    logic                  err_pulse_q, err_pulse_d;

    logic                  acc;
    logic                  done;
    logic                  bad;
    logic [4:0]            hit;
    logic [PID_WIDTH-1:0]  in_pid;
    logic [BEAT_WIDTH-1:0] in_beat;
    logic [PID_WIDTH-1:0]  done_pid;

    assign acc     = s_tvalid & s_tready_q;
    assign done    = acc & s_tlast;
    assign in_pid  = s_tdata[BEAT_WIDTH +: PID_WIDTH];
    assign in_beat = s_tdata[BEAT_WIDTH-1:0];

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            phase_q      <= 3'd0;
            s_tready_q   <= 1'b0;
            cur_pid_q    <= '0;
            last_pid_q   <= '0;
            exp_beat_q   <= '0;
            first_q      <= 1'b1;
            pkt_bad_q    <= 1'b0;
            pkt_count_q  <= '0;
            beat_count_q <= '0;
            err_count_q  <= '0;
            err_flags_q  <= '0;
            err_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            s_tready_q   <= s_tready_d;
            cur_pid_q    <= cur_pid_d;
            last_pid_q   <= last_pid_d;
            exp_beat_q   <= exp_beat_d;
            first_q      <= first_d;
            pkt_bad_q    <= pkt_bad_d;
            pkt_count_q  <= pkt_count_d;
            beat_count_q <= beat_count_d;
            err_count_q  <= err_count_d;
            err_flags_q  <= err_flags_d;
            err_pulse_q  <= err_pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (acc) begin
            unique case (state_q)
                IDLE: begin
                    if (!s_tlast) state_d = (MAX_PLEN <= 1) ? DISCARD : BODY;
                end
                BODY: begin
                    if (s_tlast) state_d = IDLE;
                    else if (exp_beat_q == LAST_IDX) state_d = DISCARD;
                end
                DISCARD: begin
                    if (s_tlast) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Per-beat checks, packet bookkeeping and ready generation.
    always_comb begin
        hit        = '0;
        cur_pid_d  = cur_pid_q;
        exp_beat_d = exp_beat_q;
        done_pid   = cur_pid_q;
        if (acc) begin
            if (s_tkeep != '1) hit[2] = 1'b1;
            unique case (state_q)
                IDLE: begin
                    cur_pid_d  = in_pid;
                    done_pid   = in_pid;
                    exp_beat_d = BEAT_WIDTH'(1);
                    if (in_beat != '0) hit[0] = 1'b1;
                    if (!first_q && in_pid <= last_pid_q) hit[4] = 1'b1;
                    if (!s_tlast && MAX_PLEN <= 1) hit[3] = 1'b1;
                end
                BODY: begin
                    if (in_beat != exp_beat_q) hit[0] = 1'b1;
                    if (in_pid != cur_pid_q) hit[1] = 1'b1;
                    exp_beat_d = exp_beat_q + BEAT_WIDTH'(1);
                    if (!s_tlast && exp_beat_q == LAST_IDX) hit[3] = 1'b1;
                end
                DISCARD: ;
                default: ;
            endcase
        end

        bad          = pkt_bad_q | (|hit);
        pkt_bad_d    = done ? 1'b0 : bad;
        err_flags_d  = err_flags_q | hit;
        beat_count_d = acc ? sat_inc(beat_count_q) : beat_count_q;
        pkt_count_d  = done ? sat_inc(pkt_count_q) : pkt_count_q;
        err_count_d  = (done && bad) ? sat_inc(err_count_q) : err_count_q;
        err_pulse_d  = done & bad;
        last_pid_d   = done ? done_pid : last_pid_q;
        first_d      = done ? 1'b0 : first_q;

        // Clear beats any same-cycle update; the FSM still advances.
        if (cfg_clear) begin
            pkt_bad_d    = 1'b0;
            err_flags_d  = '0;
            beat_count_d = '0;
            pkt_count_d  = '0;
            err_count_d  = '0;
            err_pulse_d  = 1'b0;
            last_pid_d   = '0;
            first_d      = 1'b1;
        end

        phase_d    = phase_q + 3'd1;
        s_tready_d = cfg_enable & cfg_ready_pat[phase_q];
    end

    assign s_tready   = s_tready_q;
    assign pkt_count  = pkt_count_q;
    assign beat_count = beat_count_q;
    assign err_count  = err_count_q;
    assign err_flags  = err_flags_q;
    assign err_pulse  = err_pulse_q;
    assign last_pid   = last_pid_q;

endmodule

// File: tb/tb_axi_stream_pkt_checker.sv
// Bench for axi_stream_pkt_checker: directed and random packets checked
// every cycle against a packet-level reference model.
module tb_axi_stream_pkt_checker;

    localparam int MAX_PLEN = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = 8'hFF;
    logic        s_tlast = 1'b0;
    logic        cfg_enable = 1'b0;
    logic [7:0]  cfg_ready_pat = 8'h00;
    logic        cfg_clear = 1'b0;
    logic [31:0] pkt_count;
    logic [31:0] beat_count;
    logic [31:0] err_count;
    logic [4:0]  err_flags;
    logic        err_pulse;
    logic [47:0] last_pid;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [2:0]  m_phase;
    logic        m_rdy;
    int unsigned m_pkt, m_beat, m_err;
    logic [4:0]  m_flags;
    logic        m_pulse;
    logic [47:0] m_last_pid;
    logic        m_first;
    int          m_n;
    logic [47:0] m_pid;
    logic        m_bad;

    axi_stream_pkt_checker dut (
        .clk(clk), .rst_n(rst_n),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .cfg_enable(cfg_enable), .cfg_ready_pat(cfg_ready_pat),
        .cfg_clear(cfg_clear),
        .pkt_count(pkt_count), .beat_count(beat_count),
        .err_count(err_count), .err_flags(err_flags),
        .err_pulse(err_pulse), .last_pid(last_pid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    task automatic model_reset();
        m_phase = 3'd0; m_rdy = 1'b0;
        m_pkt = 0; m_beat = 0; m_err = 0;
        m_flags = '0; m_pulse = 1'b0; m_last_pid = '0;
        m_first = 1'b1; m_n = 0; m_pid = '0; m_bad = 1'b0;
    endtask

    task automatic model_clear();
        m_pkt = 0; m_beat = 0; m_err = 0;
        m_flags = '0; m_pulse = 1'b0; m_last_pid = '0;
        m_first = 1'b1; m_bad = 1'b0;
    endtask

    // m_n is the 0-based position of the beat within its packet.
    task automatic model_beat(input logic [47:0] pid, input logic [15:0] beat,
                              input logic last, input logic [7:0] keep);
        logic [4:0] f;
        f = '0;
        if (keep != 8'hFF) f[2] = 1'b1;
        if (m_n == 0) begin
            m_pid = pid;
            if (beat != 16'd0) f[0] = 1'b1;
            if (!m_first && pid <= m_last_pid) f[4] = 1'b1;
        end else if (m_n < MAX_PLEN) begin
            if (int'(beat) != m_n) f[0] = 1'b1;
            if (pid != m_pid) f[1] = 1'b1;
        end
        if (!last && m_n == MAX_PLEN - 1) f[3] = 1'b1;
        m_flags = m_flags | f;
        if (f != '0) m_bad = 1'b1;
        m_beat = sat(m_beat);
        if (last) begin
            m_pkt = sat(m_pkt);
            m_last_pid = m_pid;
            m_first = 1'b0;
            if (m_bad) begin
                m_err = sat(m_err);
                m_pulse = 1'b1;
            end
            m_n = 0;
            m_bad = 1'b0;
        end else begin
            m_n++;
        end
    endtask

    task automatic check_all();
        chk("tready", 64'(s_tready), 64'(m_rdy));
        chk("pkt_count", 64'(pkt_count), 64'(m_pkt));
        chk("beat_count", 64'(beat_count), 64'(m_beat));
        chk("err_count", 64'(err_count), 64'(m_err));
        chk("err_flags", 64'(err_flags), 64'(m_flags));
        chk("err_pulse", 64'(err_pulse), 64'(m_pulse));
        chk("last_pid", 64'(last_pid), 64'(m_last_pid));
    endtask

    // One clock: acceptance is judged from the model's own ready.
    task automatic tick(output bit acc);
        logic        rdy_n, clr, last;
        logic [47:0] pid;
        logic [15:0] beat;
        logic [7:0]  keep;
        acc   = s_tvalid && m_rdy;
        rdy_n = cfg_enable && cfg_ready_pat[m_phase];
        clr   = cfg_clear;
        pid   = s_tdata[63:16];
        beat  = s_tdata[15:0];
        last  = s_tlast;
        keep  = s_tkeep;
        @(posedge clk);
        m_phase = m_phase + 3'd1;
        m_rdy   = rdy_n;
        m_pulse = 1'b0;
        if (acc) model_beat(pid, beat, last, keep);
        if (clr) model_clear();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        bit a;
        s_tvalid = 1'b0;
        for (int i = 0; i < n; i++) tick(a);
    endtask

    task automatic send_beat(input logic [47:0] pid, input logic [15:0] beat,
                             input logic last, input logic [7:0] keep);
        bit a;
        int n;
        s_tvalid = 1'b1;
        s_tdata  = {pid, beat};
        s_tlast  = last;
        s_tkeep  = keep;
        n = 0;
        do begin
            tick(a);
            n++;
        end while (!a && n < 64);
        if (!a) chk("accept_timeout", 64'(a), 64'd1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_pkt(input logic [47:0] pid, input int len);
        for (int b = 0; b < len; b++)
            send_beat(pid, 16'(b), b == len - 1, 8'hFF);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_tvalid = 1'b0;
        cfg_clear = 1'b0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned b0;
        logic [47:0] pid;
        int len;
        logic [15:0] bt;
        logic [47:0] bp;
        logic [7:0]  kp;

        model_reset();
        #3;
        check_all();
        cfg_enable = 1'b1;
        cfg_ready_pat = 8'hFF;
        @(negedge clk);
        rst_n = 1'b1;

        // enable low keeps ready low
        cfg_enable = 1'b0;
        idle(4);
        chk("disabled_ready", 64'(s_tready), 64'd0);
        cfg_enable = 1'b1;
        idle(2);

        // clean packets of length 1, 4, 16
        send_pkt(48'd1, 1);
        send_pkt(48'd2, 4);
        send_pkt(48'd3, 16);
        idle(1);
        chk("t1_pkt", 64'(pkt_count), 64'd3);
        chk("t1_beat", 64'(beat_count), 64'd21);
        chk("t1_err", 64'(err_count), 64'd0);
        chk("t1_flags", 64'(err_flags), 64'd0);
        chk("t1_last_pid", 64'(last_pid), 64'd3);

        // sparse ready pattern with valid held high
        cfg_ready_pat = 8'b0000_0101;
        b0 = beat_count;
        send_pkt(48'd4, 10);
        idle(1);
        chk("t2_beats", 64'(beat_count - b0), 64'd10);
        cfg_ready_pat = 8'hFF;

        // beat sequence error
        cfg_clear = 1'b1;
        idle(1);
        cfg_clear = 1'b0;
        send_beat(48'd5, 16'd0, 1'b0, 8'hFF);
        send_beat(48'd5, 16'd1, 1'b0, 8'hFF);
        send_beat(48'd5, 16'd3, 1'b1, 8'hFF);
        chk("t3_pulse", 64'(err_pulse), 64'd1);
        send_pkt(48'd6, 3);
        chk("t3_flags", 64'(err_flags), 64'h01);
        chk("t3_err", 64'(err_count), 64'd1);

        // pid order and tkeep errors
        send_pkt(48'd9, 2);
        send_pkt(48'd9, 2);
        chk("t4_order", 64'(err_flags[4]), 64'd1);
        send_beat(48'd10, 16'd0, 1'b0, 8'hFF);
        send_beat(48'd10, 16'd1, 1'b0, 8'hFF);
        send_beat(48'd10, 16'd2, 1'b1, 8'h7F);
        chk("t4_keep", 64'(err_flags[2]), 64'd1);
        chk("t4_err", 64'(err_count), 64'd3);

        // overlength packet
        cfg_clear = 1'b1;
        idle(1);
        cfg_clear = 1'b0;
        send_pkt(48'd20, 20);
        chk("t5_flags", 64'(err_flags), 64'h08);
        chk("t5_pkt", 64'(pkt_count), 64'd1);
        send_pkt(48'd21, 3);
        chk("t5_err", 64'(err_count), 64'd1);
        chk("t5_pkt2", 64'(pkt_count), 64'd2);

        // clear mid-packet, coinciding with an accepted beat
        send_beat(48'd30, 16'd0, 1'b0, 8'hFF);
        send_beat(48'd30, 16'd1, 1'b0, 8'hFF);
        send_beat(48'd30, 16'd2, 1'b0, 8'hFF);
        cfg_clear = 1'b1;
        send_beat(48'd30, 16'd3, 1'b0, 8'hFF);
        cfg_clear = 1'b0;
        send_beat(48'd30, 16'd4, 1'b0, 8'hFF);
        send_beat(48'd30, 16'd5, 1'b1, 8'hFF);
        chk("t6_pkt", 64'(pkt_count), 64'd1);
        chk("t6_beat", 64'(beat_count), 64'd2);
        chk("t6_flags", 64'(err_flags), 64'd0);
        chk("t6_last_pid", 64'(last_pid), 64'd30);

        // random traffic
        pid = 48'd100;
        for (int p = 0; p < 40; p++) begin
            cfg_ready_pat = 8'($urandom_range(1, 255));
            len = $urandom_range(1, 20);
            pid = pid + 48'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                cfg_clear = 1'b1;
                idle(1);
                cfg_clear = 1'b0;
            end
            for (int b = 0; b < len; b++) begin
                bt = 16'(b);
                bp = pid;
                kp = 8'hFF;
                if ($urandom_range(0, 15) == 0) bt = bt + 16'd1;
                if (b > 0 && $urandom_range(0, 19) == 0) bp = pid + 48'd1;
                if ($urandom_range(0, 19) == 0) kp = 8'h0F;
                send_beat(bp, bt, b == len - 1, kp);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        cfg_ready_pat = 8'hFF;

        // reset mid-packet
        send_beat(pid + 48'd5, 16'd0, 1'b0, 8'hFF);
        send_beat(pid + 48'd5, 16'd1, 1'b0, 8'hFF);
        do_reset();
        send_pkt(48'd7, 2);
        chk("t7_flags", 64'(err_flags), 64'd0);
        chk("t7_pkt", 64'(pkt_count), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
